// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: word width, register index width and
// architecturally fixed register indices.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_write_decoder.sv
// Turns the write-back control (reg_write, write_reg) into a one-hot
// per-register write enable; register 0 is never enabled.
module regfile_write_decoder #(
  parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                   reg_write,
  input  logic [ADDR_W-1:0]      write_reg,
  output logic [2**ADDR_W-1:0]   write_en
);

  // The index is only used once reg_write qualifies it, so an unknown
  // destination index with writes disabled can never raise an enable.
  always_comb begin
    write_en = '0;
    if (reg_write) begin
      write_en[write_reg] = 1'b1;
    end
    write_en[0] = 1'b0;
  end

endmodule

// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: two combinational read ports, one
// synchronous write port, hardwired zero register. Optional same-cycle
// write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module mips_register_file #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  write_en;

  regfile_write_decoder #(
    .ADDR_W (ADDR_W)
  ) u_write_decoder (
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_en  (write_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (write_en[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  // Reads are forced to zero during reset so a forwarded write cannot leak
  // through while the array itself is being cleared.
  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (reg_write && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
    if (reg_write && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
`else
`endif
    if (rst || (read_reg1 == '0)) begin
      read_data1 = '0;
    end
    if (rst || (read_reg2 == '0)) begin
      read_data2 = '0;
    end
  end

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: directed scenarios followed by
// randomized traffic compared against an array model of the register file.
module tb_mips_register_file;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  logic [31:0] model [32];
  int unsigned passed;
  int unsigned total;

  mips_register_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // Value a read port must show before the next edge, given current inputs.
  function automatic logic [31:0] expect_read(input logic [4:0] idx);
    if (rst || idx == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (reg_write && write_reg == idx) return write_data;
`endif
    return model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic model_edge();
    if (!rst && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
  endtask

  task automatic edge_settle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bypass_exp;
    passed = 0;
    total  = 0;
    rst = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'h0;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    model_clear();

    // Asynchronous reset pulse in the middle of the low phase.
    @(negedge clk); #2;
    rst = 1'b1;
    read_reg1 = 5'd5; read_reg2 = 5'd31;
    #1;
    check("rst_rd1_r5", read_data1, 32'h0);
    check("rst_rd2_r31", read_data2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_r5", read_data1, 32'h0);

    // Write 0xDEADBEEF to r10.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'b01010; write_data = 32'hDEADBEEF;
    edge_settle();
    reg_write = 1'b0;
    read_reg1 = 5'd10; read_reg2 = 5'd31;
    #1;
    check("wr_r10", read_data1, 32'hDEADBEEF);
    check("r31_untouched", read_data2, 32'h0);

    // Write r31 then hold reg_write low with garbage data for three edges.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'b11111; write_data = 32'h12345678;
    edge_settle();
    reg_write = 1'b0; write_data = 32'hFFFFFFFF;
    repeat (3) edge_settle();
    read_reg2 = 5'd31;
    #1;
    check("r31_hold", read_data2, 32'h12345678);

    // Writes to r0 are discarded.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    read_reg1 = 5'd0;
    edge_settle();
    check("r0_zero", read_data1, 32'h0);
    reg_write = 1'b0;

    // Unknown write index with writes disabled.
    @(negedge clk);
    write_reg = 5'bxxxxx; write_data = 32'h0BAD0BAD;
    edge_settle();
    read_reg1 = 5'd10; read_reg2 = 5'd31;
    #1;
    check("x_idx_r10", read_data1, 32'hDEADBEEF);
    check("x_idx_r31", read_data2, 32'h12345678);

    // Same-cycle collision on r8; both ports read the same index.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h1;
    edge_settle();
    write_data = 32'h2;
    read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    bypass_exp = 32'h2;
`else
    bypass_exp = 32'h1;
`endif
    check("collide_pre_rd1", read_data1, bypass_exp);
    check("collide_pre_rd2", read_data2, bypass_exp);
    edge_settle();
    check("collide_post_rd1", read_data1, 32'h2);
    check("collide_post_rd2", read_data2, 32'h2);

    // Reset coincident with a write to r3 wins.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hAAAA5555;
    edge_settle();
    read_reg1 = 5'd3;
    #1;
    check("r3_loaded", read_data1, 32'hAAAA5555);
    @(negedge clk);
    write_data = 32'h1;
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_during_wr", read_data1, 32'h0);
    edge_settle();
    @(negedge clk);
    rst = 1'b0;
    reg_write = 1'b0;
    #1;
    check("r3_after_rst", read_data1, 32'h0);
    read_reg2 = 5'd10;
    #1;
    check("r10_after_rst", read_data2, 32'h0);

    // First write after reset release lands on the first edge.
    @(posedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    reg_write = 1'b1; write_reg = 5'd4; write_data = 32'h00000044;
    read_reg1 = 5'd4;
    edge_settle();
    check("first_wr_after_rst", read_data1, 32'h00000044);
    reg_write = 1'b0;

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = (n % 4 == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = 5'($urandom_range(0, 31));
      #1;
      check("rand_pre_rd1", read_data1, expect_read(read_reg1));
      check("rand_pre_rd2", read_data2, expect_read(read_reg2));
      edge_settle();
      reg_write = 1'b0;
      #1;
      check("rand_post_rd1", read_data1, expect_read(read_reg1));
      check("rand_post_rd2", read_data2, expect_read(read_reg2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_register_file.md
MIPS_REGISTER_FILE -- requirements
Module: mips_register_file

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning register index width; depth is 2**ADDR_W (32).
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The module SHALL have port reg_write  input  1  write enable from control.
REQ-006 The module SHALL have port write_reg  input  ADDR_W  destination index, driven by the destination-register mux output.
REQ-007 The module SHALL have port write_data  input  DATA_W  write-back value.
REQ-008 The module SHALL have port read_reg1  input  ADDR_W  rs index.
REQ-009 The module SHALL have port read_reg2  input  ADDR_W  rt index.
REQ-010 The module SHALL have port read_data1  output  DATA_W  contents of read_reg1.
REQ-011 The module SHALL have port read_data2  output  DATA_W  contents of read_reg2.

Function
REQ-012 The module SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-013 On each rising clk edge with reg_write=1 and write_reg!=0, the module SHALL store write_data in register write_reg.
REQ-014 With reg_write=0, the module SHALL leave all registers unchanged.
REQ-015 Writes to index 0 SHALL be discarded, and reads of index 0 SHALL return 0 in every cycle.
REQ-016 Reads SHALL be combinational with zero-cycle latency: read_dataN follows read_regN and the register contents within the same cycle.
REQ-017 A value written at edge N SHALL be visible on the read ports from edge N onward, with no extra cycle.
REQ-018 Both read ports SHALL be independent, and read_reg1==read_reg2 SHALL return identical data on both ports.
REQ-019 When the write and read indices collide in the same cycle, the read result SHALL follow the Configuration section.
REQ-020 X or Z on write_reg while reg_write=0 SHALL NOT corrupt any register.

Reset
REQ-021 While rst=1, all registers SHALL be 0 and read_data1 and read_data2 SHALL be 0, independent of clk.
REQ-022 rst asserted mid-write SHALL win over the write: the register ends at 0.
REQ-023 The first write after rst deasserts SHALL take effect on the first rising clk edge at which rst=0.

Configuration
REQ-024 When macro REGFILE_WRITE_BYPASS_EN is defined, a read whose index equals write_reg, with reg_write=1 and a nonzero index, SHALL return write_data combinationally in the same cycle.
REQ-025 When REGFILE_WRITE_BYPASS_EN is undefined, such a read SHALL return the stored pre-edge value until the edge.
REQ-026 Index 0 SHALL read 0 in both builds.

Structure
REQ-027 The shared package mips_pkg SHALL hold DATA_W, REG_ADDR_W, REG_ZERO (index 0) and REG_RA (index 31) constants; the module's default parameter values SHALL come from it.
REQ-028 One sub-module, regfile_write_decoder, SHALL convert reg_write and write_reg into a one-hot per-register enable vector with bit 0 forced low.
REQ-029 There SHALL be no other sub-modules.

Verification
REQ-030 The bench SHALL cover: rst=1 pulsed mid-cycle, then read_reg1=5, read_reg2=31 -> both outputs 0x00000000.
REQ-031 The bench SHALL cover: reg_write=1, write_reg=5'b01010, write_data=0xDEADBEEF, one edge, then read_reg1=10 -> 0xDEADBEEF, while reg 31 still reads 0.
REQ-032 The bench SHALL cover: reg_write=1, write_reg=5'b11111, write_data=0x12345678, then reg_write=0 with write_data=0xFFFFFFFF for 3 edges -> read_reg2=31 returns 0x12345678.
REQ-033 The bench SHALL cover: reg_write=1, write_reg=0, write_data=0xFFFFFFFF -> read_reg1=0 returns 0 after the edge.
REQ-034 The bench SHALL cover: with reg 8 holding 0x1, write_reg=8 with write_data=0x2, read_reg1=8 before the edge -> 0x2 with REGFILE_WRITE_BYPASS_EN defined, 0x1 without it; 0x2 after the edge in both builds.
REQ-035 The bench SHALL cover: reg 3 holding 0xAAAA5555 and rst asserted coincident with a write of 0x1 to reg 3 -> reg 3 reads 0 after rst deasserts.
